// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared LC-3b types used by the physical-memory arbiter:
//                machine word, cache line and arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int C_WORD_WIDTH = 16;
    localparam int C_LINE_WIDTH = 128;

    typedef logic [C_WORD_WIDTH-1:0] lc3b_word;
    typedef logic [C_LINE_WIDTH-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one physical-memory port between the instruction and
//                data caches. Data side wins ties (older instruction in MEM),
//                with a starvation limit that forces an I grant after
//                STARVE_LIMIT consecutive D grants while I was waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction cache side
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    // data cache side
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    // shared memory side
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int                c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    arb_state_t              r_state;
    logic [c_cnt_w-1:0]      r_starve;
    logic                    r_op_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_wdata;

    logic                    w_d_req;
    logic                    w_grant_i;
    logic                    w_grant_d;
    logic                    w_serving;
    logic [c_cnt_w-1:0]      w_starve_next;

    // Grant selection: D wins ties unless I has waited through c_limit D grants.
    always_comb begin
        w_d_req   = d_pmem_read | d_pmem_write;
        w_grant_i = i_pmem_read & (~w_d_req | (r_starve == c_limit));
        w_grant_d = w_d_req & ~w_grant_i;
        if (!i_pmem_read) begin
            w_starve_next = '0;
        end else if (r_starve == c_limit) begin
            w_starve_next = r_starve;
        end else begin
            w_starve_next = r_starve + 1'b1;
        end
    end

    // Arbiter FSM with transaction latch and starvation counter, all updated at grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_starve   <= '0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_state    <= SERVE_I;
                        r_op_write <= 1'b0;
                        r_addr     <= i_pmem_address;
                        r_wdata    <= '0;
                        r_starve   <= '0;
                    end else if (w_grant_d) begin
                        // A simultaneous read+write is treated as a write.
                        r_state    <= SERVE_D;
                        r_op_write <= d_pmem_write;
                        r_addr     <= d_pmem_address;
                        r_wdata    <= d_pmem_wdata;
                        r_starve   <= w_starve_next;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Bubble cycle: lets the served cache drop its request.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Downstream port is driven only from the grant latch; completion is routed to the owner.
    always_comb begin
        w_serving    = (r_state == SERVE_I) | (r_state == SERVE_D);
        pmem_read    = w_serving & ~r_op_write;
        pmem_write   = w_serving & r_op_write;
        pmem_address = r_addr;
        pmem_wdata   = r_wdata;
        i_pmem_resp  = (r_state == SERVE_I) & pmem_resp;
        d_pmem_resp  = (r_state == SERVE_D) & pmem_resp;
        i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
        d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;
    end

`ifndef SYNTHESIS
    // Illegal request patterns from the caches.
    a_d_rw_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write));
    a_i_held : assert property (@(posedge clk) disable iff (rst)
        (r_state == SERVE_I) |-> i_pmem_read);
    a_d_held : assert property (@(posedge clk) disable iff (rst)
        (r_state == SERVE_D) |-> (d_pmem_read || d_pmem_write));
`endif

endmodule : mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single physical-memory port between the pipeline's instruction cache and data cache in the LC-3b core.
- Fetch-side and MEM-stage line misses can now be outstanding at the same time.
- Fixed priority favours the data cache, because the MEM stage holds the older instruction. A starvation limit guarantees instruction-fetch progress.
- Sits between the two caches' pmem-side interfaces and the shared memory / L2 port.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- LINE_WIDTH, 128, cache line width in bits.
- STARVE_LIMIT, 4, consecutive D grants allowed while an I request waits; the next grant then goes to I.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_pmem_read  in  1  icache line-read request
- i_pmem_address  in  ADDR_WIDTH  icache line address
- i_pmem_rdata  out  LINE_WIDTH  line data to icache
- i_pmem_resp  out  1  icache completion strobe
- d_pmem_read  in  1  dcache line-read request
- d_pmem_write  in  1  dcache line-writeback request
- d_pmem_address  in  ADDR_WIDTH  dcache line address
- d_pmem_wdata  in  LINE_WIDTH  dcache writeback data
- d_pmem_rdata  out  LINE_WIDTH  line data to dcache
- d_pmem_resp  out  1  dcache completion strobe
- pmem_read  out  1  downstream read
- pmem_write  out  1  downstream write
- pmem_address  out  ADDR_WIDTH  downstream address
- pmem_wdata  out  LINE_WIDTH  downstream write data
- pmem_rdata  in  LINE_WIDTH  downstream read data
- pmem_resp  in  1  downstream completion strobe

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, starve count=0, latched op/address/wdata=0; all outputs 0 (pmem_read, pmem_write, pmem_address, pmem_wdata, both resp strobes, both rdata buses).
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE, grant selection (evaluated each cycle):
  - Only I requests -> SERVE_I.
  - Only D requests (read or write) -> SERVE_D.
  - Both request -> SERVE_I if starve count == STARVE_LIMIT, else SERVE_D.
  - Neither -> stay in IDLE.
- Grant latch: on the grant edge, latch the requester's op (read/write), address and wdata. The downstream port is driven only from these latches, so requester signal changes after grant have no effect.
- Downstream drive: in SERVE_*, pmem_read or pmem_write is held high until pmem_resp. In IDLE and DONE both are 0.
- Latency: request sampled in IDLE at cycle N -> pmem_read/pmem_write high at cycle N+1.
- Completion: in SERVE_* with pmem_resp=1:
  - Same cycle, combinationally: assert the granted requester's resp and pass pmem_rdata to that requester's rdata.
  - The other requester's resp stays 0 and its rdata stays 0.
  - Next state is DONE.
- DONE: one mandatory bubble cycle so the served requester can drop its request. Always -> IDLE. A request still high in DONE is not sampled.
- Write precedence: d_pmem_read and d_pmem_write both high is illegal. Treat it as a write and flag it with a simulation assertion.
- Starve count, width $clog2(STARVE_LIMIT+1), updated at grant only:
  - I grant -> 0.
  - D grant with i_pmem_read high -> +1, saturating at STARVE_LIMIT.
  - D grant with i_pmem_read low -> 0.
- Request dropped before resp: illegal. The latched transaction still completes to memory, and a simulation assertion fires.
- pmem_resp outside SERVE_*: ignored; no requester resp is asserted.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The downstream memory shares rst.
- Throughput: at most one transaction per 3 cycles plus memory latency; back-to-back grants are separated by DONE and IDLE.

Decomposition:
- lc3b_types package gains:
  - lc3b_line (LINE_WIDTH-bit line typedef);
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, DONE}.
- Address uses the existing lc3b_word.
- No sub-module: the FSM, starvation counter and transaction latch are a single ~150-line block.

Test Plan:
- Single I read: i_pmem_read, address 0x1230; memory responds after 3 cycles with line A -> pmem_read high from cycle 1, pmem_address=0x1230, i_pmem_resp pulses once with i_pmem_rdata=A, d_pmem_resp=0 throughout.
- D writeback: d_pmem_write, address 0x4000, wdata 0xDEAD...BEEF -> pmem_write=1 and pmem_wdata exact until resp; d_pmem_resp is one pulse; next grant no earlier than 2 cycles after resp.
- Simultaneous I read 0x0100 and D read 0x2000 -> D is served first, then I; each resp is routed only to its owner.
- Starvation: I held continuously while D re-requests 6 times -> exactly 4 D grants, then an I grant, then D resumes; count returns to 0 after the I grant.
- rst asserted during SERVE_D before pmem_resp -> all outputs 0 immediately; after release with no requests, the block stays in IDLE and no spurious resp appears.
- Requester address changes after grant (0x3000 -> 0x3FF0) -> pmem_address stays 0x3000 until resp.
